// File: rtl/ps2_letter_decoder.sv
// ps2_letter_decoder: PS/2 frame receiver that turns A-Z and Enter make codes into letter/enter strobes.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses typematic repeats of the held key.
module ps2_letter_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [4:0] char,
  output logic       letter_valid,
  output logic       enter_pulse,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [2:0] clk_sy;
  logic [1:0] dat_sy;
  logic fall, dat, timeout;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, shreg_n, rx_byte, rx_byte_n;
  logic par, par_n, armed, armed_n, byte_rdy, byte_rdy_n, frame_err_n;
  logic [WW-1:0] wd, wd_n;
  logic brk, brk_n, ext, ext_n, lv_n, ep_n, rpt;
  logic [4:0] char_n, code;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0] held, held_n;
  assign rpt = rx_byte == held;
`else
  assign rpt = 1'b0;
`endif
  assign fall = clk_sy[2] & ~clk_sy[1];
  assign dat = dat_sy[1];
  assign timeout = wd == WW'(TIMEOUT_CYCLES - 1);
  assign rx_busy = state != IDLE;
  // armed stays low after reset until the line has been quiet for a full timeout, so a frame cut by reset is never picked up halfway
  always_comb begin
    state_n = state;
    bitcnt_n = bitcnt;
    shreg_n = shreg;
    par_n = par;
    rx_byte_n = rx_byte;
    byte_rdy_n = 1'b0;
    frame_err_n = 1'b0;
    armed_n = armed | timeout;
    wd_n = (fall || timeout || (state == IDLE && armed)) ? '0 : wd + 1'b1;
    if (fall) begin
      case (state)
        IDLE: if (!dat && armed) begin
          state_n = DATA;
          bitcnt_n = '0;
        end
        DATA: begin
          shreg_n = {dat, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          state_n = bitcnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_n = dat;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          rx_byte_n = shreg;
          byte_rdy_n = dat & (^{shreg, par});
          frame_err_n = ~(dat & (^{shreg, par}));
        end
      endcase
    end else if (state != IDLE && timeout) begin
      state_n = IDLE;
      frame_err_n = 1'b1;
    end
  end
  always_comb begin
    case (rx_byte)
      8'h1C: code = 5'd1;
      8'h32: code = 5'd2;
      8'h21: code = 5'd3;
      8'h23: code = 5'd4;
      8'h24: code = 5'd5;
      8'h2B: code = 5'd6;
      8'h34: code = 5'd7;
      8'h33: code = 5'd8;
      8'h43: code = 5'd9;
      8'h3B: code = 5'd10;
      8'h42: code = 5'd11;
      8'h4B: code = 5'd12;
      8'h3A: code = 5'd13;
      8'h31: code = 5'd14;
      8'h44: code = 5'd15;
      8'h4D: code = 5'd16;
      8'h15: code = 5'd17;
      8'h2D: code = 5'd18;
      8'h1B: code = 5'd19;
      8'h2C: code = 5'd20;
      8'h3C: code = 5'd21;
      8'h2A: code = 5'd22;
      8'h1D: code = 5'd23;
      8'h22: code = 5'd24;
      8'h35: code = 5'd25;
      8'h1A: code = 5'd26;
      default: code = 5'd0;
    endcase
  end
  always_comb begin
    brk_n = brk;
    ext_n = ext;
    char_n = char;
    lv_n = 1'b0;
    ep_n = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    held_n = held;
`endif
    if (byte_rdy) begin
      if (rx_byte == 8'hF0) brk_n = 1'b1;
      else if (rx_byte == 8'hE0) ext_n = 1'b1;
      else if (brk) begin
        brk_n = 1'b0;
        ext_n = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_n = rpt ? '0 : held;
`endif
      end else if (ext) begin
        ext_n = 1'b0;
        ep_n = rx_byte == 8'h5A;
      end else if (rx_byte == 8'h5A && !rpt) begin
        ep_n = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_n = rx_byte;
`endif
      end else if (code != 5'd0 && !rpt) begin
        char_n = code;
        lv_n = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_n = rx_byte;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sy <= '0;
      dat_sy <= '0;
      state <= IDLE;
      bitcnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      rx_byte <= '0;
      byte_rdy <= 1'b0;
      frame_err <= 1'b0;
      armed <= 1'b0;
      wd <= '0;
      brk <= 1'b0;
      ext <= 1'b0;
      char <= '0;
      letter_valid <= 1'b0;
      enter_pulse <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held <= '0;
`endif
    end else begin
      clk_sy <= {clk_sy[1:0], ps2_clk};
      dat_sy <= {dat_sy[0], ps2_dat};
      state <= state_n;
      bitcnt <= bitcnt_n;
      shreg <= shreg_n;
      par <= par_n;
      rx_byte <= rx_byte_n;
      byte_rdy <= byte_rdy_n;
      frame_err <= frame_err_n;
      armed <= armed_n;
      wd <= wd_n;
      brk <= brk_n;
      ext <= ext_n;
      char <= char_n;
      letter_valid <= lv_n;
      enter_pulse <= ep_n;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held <= held_n;
`endif
    end
  end
endmodule
